// File: rtl/spu_sched_pkg.sv
// spu_sched_pkg: shared types, sizes and helpers for the SPU dual-issue scheduler.
//   reg_addr_t  - architectural register address
//   lat_t       - result latency / countdown value
//   issue_req_t - one decoded instruction slot as seen by the scoreboard
//   lat_norm    - maps an illegal latency of 0 to 1
package spu_sched_pkg;

    localparam int NUM_REGS    = 128;
    localparam int REG_ADDR_W  = 7;
    localparam int LAT_W       = 3;
    localparam int STALL_CNT_W = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [LAT_W-1:0]      lat_t;

    // src[2]/src[1]/src[0] line up with src_vld bits {ra, rb, rc/rt_st}
    typedef struct packed {
        logic            valid;
        reg_addr_t [2:0] src;
        logic      [2:0] src_vld;
        reg_addr_t       rt;
        logic            wr;
        lat_t            lat;
    } issue_req_t;

    function automatic lat_t lat_norm(input lat_t l);
        return (l == '0) ? lat_t'(1) : l;
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// scoreboard_entry: per-register countdown until the pending write becomes forwardable.
//   clock, reset (async, active-low), flush - clear the countdown
//   load, lat                               - start a write of latency lat (must be non-zero)
//   ready                                   - countdown is zero, value readable
module scoreboard_entry
    import spu_sched_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic load,
    input  lat_t lat,
    output logic ready
);

    lat_t cnt;
    lat_t dec;
    lat_t fresh;

    assign dec   = (cnt == '0) ? '0 : cnt - lat_t'(1);
    assign fresh = lat - lat_t'(1);
    assign ready = (cnt == '0);

    // A newer, shorter write must never expose the register before an older one lands
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else if (load)
            cnt <= (fresh > dec) ? fresh : dec;
        else
            cnt <= dec;

endmodule

// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: in-order grant logic for the even/odd SPU pipes with RAW/WAW tracking.
//   clock, reset (async, active-low), flush - kill all in-flight writes
//   *_even / *_odd                          - decoded slot requests (even is older)
//   grant_even, grant_odd                   - slot issues this cycle (combinational)
//   stall, stall_cycles                     - request not fully granted, saturating count
module dual_issue_scoreboard
    import spu_sched_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   req_even,
    input  reg_addr_t              ra_even,
    input  reg_addr_t              rb_even,
    input  reg_addr_t              rc_even,
    input  logic [2:0]             src_vld_even,
    input  reg_addr_t              rt_even,
    input  logic                   wr_even,
    input  lat_t                   lat_even,
    input  logic                   req_odd,
    input  reg_addr_t              ra_odd,
    input  reg_addr_t              rb_odd,
    input  reg_addr_t              rt_st_odd,
    input  logic [2:0]             src_vld_odd,
    input  reg_addr_t              rt_odd,
    input  logic                   wr_odd,
    input  lat_t                   lat_odd,
    output logic                   grant_even,
    output logic                   grant_odd,
    output logic                   stall,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    issue_req_t          ev;
    issue_req_t          od;
    logic [NUM_REGS-1:0] ready;

    assign ev = {req_even, ra_even, rb_even, rc_even, src_vld_even, rt_even, wr_even, lat_even};
    assign od = {req_odd, ra_odd, rb_odd, rt_st_odd, src_vld_odd, rt_odd, wr_odd, lat_odd};

    function automatic logic src_ok(input issue_req_t x, input logic [NUM_REGS-1:0] rdy);
        src_ok = 1'b1;
        for (int i = 0; i < 3; i++)
            if (x.src_vld[i] && !rdy[x.src[i]])
                src_ok = 1'b0;
    endfunction

    function automatic logic reads(input issue_req_t x, input reg_addr_t r);
        reads = 1'b0;
        for (int i = 0; i < 3; i++)
            if (x.src_vld[i] && x.src[i] == r)
                reads = 1'b1;
    endfunction

    // Odd may only follow a granted (or absent) even, and must not consume or
    // overwrite the even result in the same cycle.
    always_comb begin
        grant_even = reset & ev.valid & src_ok(ev, ready) & ~flush;
        grant_odd  = reset & od.valid & src_ok(od, ready) & ~flush & (grant_even | ~ev.valid)
                   & ~(grant_even & ev.wr & (reads(od, ev.rt) | (od.wr & (od.rt == ev.rt))));
        stall      = reset & ((ev.valid & ~grant_even) | (od.valid & ~grant_odd));
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
        logic ld_e;
        logic ld_o;
        assign ld_e = grant_even & ev.wr & (ev.rt == reg_addr_t'(r));
        assign ld_o = grant_odd & od.wr & (od.rt == reg_addr_t'(r));
        scoreboard_entry u_entry (
            .clock (clock),
            .reset (reset),
            .flush (flush),
            .load  (ld_e | ld_o),
            .lat   (ld_e ? lat_norm(ev.lat) : lat_norm(od.lat)),
            .ready (ready[r])
        );
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            stall_cycles <= '0;
        else if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + STALL_CNT_W'(1);

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb_dual_issue_scoreboard: directed scoreboard bench for dual_issue_scoreboard.
module tb_dual_issue_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        req_even = 1'b0;
    logic [6:0]  ra_even = '0, rb_even = '0, rc_even = '0, rt_even = '0;
    logic [2:0]  src_vld_even = '0, lat_even = 3'd1;
    logic        wr_even = 1'b0;
    logic        req_odd = 1'b0;
    logic [6:0]  ra_odd = '0, rb_odd = '0, rt_st_odd = '0, rt_odd = '0;
    logic [2:0]  src_vld_odd = '0, lat_odd = 3'd1;
    logic        wr_odd = 1'b0;
    logic        grant_even, grant_odd, stall;
    logic [15:0] stall_cycles;

    typedef struct {
        logic        ge;
        logic        go;
        logic        st;
        logic [15:0] sc;
        string       nm;
    } exp_t;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [15:0] sc_exp = '0;

    dual_issue_scoreboard dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .req_even     (req_even),
        .ra_even      (ra_even),
        .rb_even      (rb_even),
        .rc_even      (rc_even),
        .src_vld_even (src_vld_even),
        .rt_even      (rt_even),
        .wr_even      (wr_even),
        .lat_even     (lat_even),
        .req_odd      (req_odd),
        .ra_odd       (ra_odd),
        .rb_odd       (rb_odd),
        .rt_st_odd    (rt_st_odd),
        .src_vld_odd  (src_vld_odd),
        .rt_odd       (rt_odd),
        .wr_odd       (wr_odd),
        .lat_odd      (lat_odd),
        .grant_even   (grant_even),
        .grant_odd    (grant_odd),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // monitor: compare whatever the driver promised for the cycle being sampled
    always @(negedge clock)
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.nm, ".grant_even"}, 16'(grant_even), 16'(e.ge));
            chk({e.nm, ".grant_odd"}, 16'(grant_odd), 16'(e.go));
            chk({e.nm, ".stall"}, 16'(stall), 16'(e.st));
            chk({e.nm, ".stall_cycles"}, stall_cycles, e.sc);
        end

    task automatic set_even(input logic [6:0] ra, rb, rc, input logic [2:0] sv,
                            input logic [6:0] rt, input logic wr, input logic [2:0] lat);
        ra_even = ra; rb_even = rb; rc_even = rc; src_vld_even = sv;
        rt_even = rt; wr_even = wr; lat_even = lat;
    endtask

    task automatic set_odd(input logic [6:0] ra, rb, rs, input logic [2:0] sv,
                           input logic [6:0] rt, input logic wr, input logic [2:0] lat);
        ra_odd = ra; rb_odd = rb; rt_st_odd = rs; src_vld_odd = sv;
        rt_odd = rt; wr_odd = wr; lat_odd = lat;
    endtask

    // apply requests for the current cycle, queue the expected outcome, advance one cycle
    task automatic cyc(input logic re, input logic ro, input logic fl,
                       input logic ege, input logic ego, input string nm);
        exp_t e;
        logic st;
        req_even = re;
        req_odd  = ro;
        flush    = fl;
        st = reset & ((re & ~ege) | (ro & ~ego));
        e.ge = ege; e.go = ego; e.st = st; e.sc = sc_exp; e.nm = nm;
        q.push_back(e);
        if (st) sc_exp = sc_exp + 16'd1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        #1;
        // reset held low with a request pending
        set_even(7'd5, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 0, 0, "reset0");
        cyc(1, 0, 0, 0, 0, "reset1");
        reset = 1'b1;
        // lat 1 producer, consumer issues next cycle
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd5, 1'b1, 3'd1);
        cyc(1, 0, 0, 1, 0, "lat1_issue");
        set_even(7'd5, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 1, 0, "lat1_nobubble");
        // RAW on rb, latency 4
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd7, 1'b1, 3'd4);
        cyc(1, 0, 0, 1, 0, "raw_issue");
        set_even(7'd0, 7'd7, 7'd0, 3'b010, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 0, 0, "raw_t1");
        cyc(1, 0, 0, 0, 0, "raw_t2");
        cyc(1, 0, 0, 0, 0, "raw_t3");
        cyc(1, 0, 0, 1, 0, "raw_t4");
        // intra-pair RAW
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd5, 1'b1, 3'd1);
        set_odd(7'd5, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 1, 0, 1, 0, "intra_pair");
        cyc(0, 1, 0, 0, 1, "intra_next");
        // intra-pair RAW through the store-data source
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd40, 1'b1, 3'd1);
        set_odd(7'd0, 7'd0, 7'd40, 3'b001, 7'd0, 1'b0, 3'd1);
        cyc(1, 1, 0, 1, 0, "intra_st");
        cyc(0, 1, 0, 0, 1, "intra_st_next");
        // same-cycle WAW
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd9, 1'b1, 3'd1);
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 7'd9, 1'b1, 3'd1);
        cyc(1, 1, 0, 1, 0, "waw_same");
        cyc(0, 1, 0, 0, 1, "waw_same_next");
        // in-flight WAW: lat 6 then lat 2 to r3
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 7'd0, 1'b0, 3'd1);
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1'b1, 3'd6);
        cyc(1, 0, 0, 1, 0, "waw_long");
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd3, 1'b1, 3'd2);
        cyc(1, 0, 0, 1, 0, "waw_short");
        set_even(7'd3, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 0, 0, "waw_t2");
        cyc(1, 0, 0, 0, 0, "waw_t3");
        cyc(1, 0, 0, 0, 0, "waw_t4");
        cyc(1, 0, 0, 0, 0, "waw_t5");
        cyc(1, 0, 0, 1, 0, "waw_t6");
        // in-order hold behind even reading r12
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd12, 1'b1, 3'd4);
        cyc(1, 0, 0, 1, 0, "hold_prod");
        set_even(7'd12, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        set_odd(7'd1, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 1, 0, 0, 0, "hold_1");
        cyc(1, 1, 0, 0, 0, "hold_2");
        cyc(1, 1, 0, 0, 0, "hold_3");
        cyc(1, 1, 0, 1, 1, "hold_both");
        // flush clears a long pending write
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 7'd0, 1'b0, 3'd1);
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd20, 1'b1, 3'd7);
        cyc(1, 0, 0, 1, 0, "flush_prod");
        set_even(7'd20, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 1, 1, 0, 0, "flush_cyc");
        cyc(1, 0, 0, 1, 0, "flush_after");
        // lat 0 behaves as lat 1
        set_even(7'd0, 7'd0, 7'd0, 3'b000, 7'd30, 1'b1, 3'd0);
        cyc(1, 0, 0, 1, 0, "lat0_issue");
        set_even(7'd0, 7'd0, 7'd30, 3'b001, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 1, 0, "lat0_reader");
        // register 0 is tracked, odd producer latency 3
        set_odd(7'd0, 7'd0, 7'd0, 3'b000, 7'd0, 1'b1, 3'd3);
        cyc(0, 1, 0, 0, 1, "r0_prod");
        set_even(7'd0, 7'd0, 7'd0, 3'b100, 7'd0, 1'b0, 3'd1);
        cyc(1, 0, 0, 0, 0, "r0_t1");
        cyc(1, 0, 0, 0, 0, "r0_t2");
        cyc(1, 0, 0, 1, 0, "r0_t3");
        cyc(0, 0, 0, 0, 0, "idle");
        repeat (3) @(posedge clock);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
